wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back pipeline stage of the RV32 core, directly downstream of the memory stage.
- Registers the instruction leaving M, then forms the register-file write port (enable, rd, data) for the cycle the instruction sits in W.
- Performs load-data byte/halfword selection with sign/zero extension and selects the result source.
- Maintains the retired-instruction counter.

Parameters:
NOP_INSTR, 32'h00000013, value loaded into the W instruction register on reset and flush.
CNT_W, 64, width of retired-instruction counter.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
m_valid  input  1  M stage holds a valid instruction
m_instr  input  32  instruction word from M
m_alu_result  input  32  ALU result / effective address from M
m_mem_rdata  input  32  raw aligned data-memory read word
m_pc_plus4  input  32  PC+4 of the M instruction
stall  input  1  hold W contents this edge
flush  input  1  load bubble into W this edge; overrides stall
w_valid  output  1  W holds a valid instruction
rf_we  output  1  register-file write enable
rf_rd  output  5  destination register index
rf_wdata  output  32  write data
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - W register: valid=0, instr=NOP_INSTR, data fields=0.
  - instret=0.
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - Reset asserted mid-operation discards the W contents immediately, with no partial retire.
- W register update at each posedge clk, highest priority first:
  - flush=1: valid<=0, instr<=NOP_INSTR.
  - else stall=1: all fields hold.
  - else: capture m_valid, m_instr, m_alu_result, m_mem_rdata, m_pc_plus4.
- Latency: an M instruction captured at edge N drives the rf_* outputs during cycle N..N+1. The register file commits it at edge N+1.
- Field decode from the W instr: opcode=instr[6:2], rd=instr[11:7], funct3=instr[14:12].
- Write enable:
  - rf_we=1 iff w_valid=1, opcode is not 01000 (store) or 11000 (branch), and rd!=0.
- Result select:
  - opcode 00000 (LOAD): rf_wdata = extended load data.
  - opcode 11011 (JAL) or 11001 (JALR): rf_wdata = pc_plus4.
  - All other opcodes: rf_wdata = alu_result.
- Load extension, with off = alu_result[1:0]:
  - funct3 000 LB: byte rdata[off*8+:8], sign-extended.
  - funct3 100 LBU: same byte, zero-extended.
  - funct3 001 LH: halfword rdata[alu_result[1]*16+:16], sign-extended. off[0] is ignored, so misaligned accesses are not trapped here.
  - funct3 101 LHU: same halfword, zero-extended.
  - funct3 010 LW: full word; off is ignored.
  - funct3 011/110/111: raw rdata word.
- Output gating: when w_valid=0, rf_rd=0 and rf_wdata=0.
- Retire counter:
  - instret increments by 1 at each edge where w_valid=1 and stall=0, including edges with flush=1.
  - A W instruction flushed while stall=1 does not count.
  - On reaching all-ones, instret wraps to 0 with no sticky flag.
- Stall behaviour:
  - During stall, rf_we/rf_rd/rf_wdata are held constant; rewriting the same value is permitted.
  - The instruction counts once, on its release edge.
- Store and branch instructions retire (count) even though rf_we=0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a valid ADD in W -> w_valid, rf_we and instret drop to 0 without waiting for a clock edge.
- LB: rd=5, alu_result=0x1002, rdata=0x12803456 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xFFFFFF80.
- LHU and LH: alu_result=0x2002, rdata=0xBEEF1234:
  - LHU -> 0x0000BEEF.
  - LH with alu_result=0x2000 -> 0x00001234.
- SW with instr[11:7]=7, then BEQ -> rf_we=0 both cycles; instret +2. ADDI with rd=0 -> rf_we=0; instret +1.
- JAL rd=1, pc_plus4=0x00000104, alu_result=0xDEAD -> rf_wdata=0x00000104. Back-to-back ADD follows -> its alu_result appears the next cycle.
- Valid ADD in W, stall held 3 cycles -> rf outputs constant, instret unchanged until the release edge, then +1. Then stall=1 with flush=1 -> w_valid=0 next cycle and no increment.

Source files
------------

// File: rtl/wb_stage_if.sv
// Bundle between the memory stage and the write-back stage: M-side capture
// inputs with pipeline control, and the register-file write port with retire count.
interface wb_stage_if #(
  parameter int CNT_W = 64
);
  logic             m_valid;
  logic [31:0]      m_instr;
  logic [31:0]      m_alu_result;
  logic [31:0]      m_mem_rdata;
  logic [31:0]      m_pc_plus4;
  logic             stall;
  logic             flush;
  logic             w_valid;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic [CNT_W-1:0] instret;

  modport master (
    output m_valid, m_instr, m_alu_result, m_mem_rdata, m_pc_plus4, stall, flush,
    input  w_valid, rf_we, rf_rd, rf_wdata, instret
  );

  modport slave (
    input  m_valid, m_instr, m_alu_result, m_mem_rdata, m_pc_plus4, stall, flush,
    output w_valid, rf_we, rf_rd, rf_wdata, instret
  );
endinterface

// File: rtl/wb_stage.sv
// RV32 write-back stage: registers the M instruction, builds the register-file
// write port (load extension, result select) and keeps the retired-instruction count.
module wb_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_stage_if.slave     bus
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  logic             r_valid;
  logic [31:0]      r_instr;
  logic [31:0]      r_alu;
  logic [31:0]      r_rdata;
  logic [31:0]      r_pc4;
  logic [CNT_W-1:0] r_instret;

  logic [4:0]  w_opc;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_result;
  logic        w_writes_rf;
  logic        w_unused;

  // Flush wins over stall; data fields are left as-is on flush since valid=0 gates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_alu   <= '0;
      r_rdata <= '0;
      r_pc4   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (!bus.stall) begin
      r_valid <= bus.m_valid;
      r_instr <= bus.m_instr;
      r_alu   <= bus.m_alu_result;
      r_rdata <= bus.m_mem_rdata;
      r_pc4   <= bus.m_pc_plus4;
    end
  end

  // An instruction retires on the edge it leaves W, flushed or not, but never while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (r_valid && !bus.stall) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign w_opc    = r_instr[6:2];
  assign w_rd     = r_instr[11:7];
  assign w_funct3 = r_instr[14:12];
  assign w_unused = ^{r_instr[31:15], r_instr[1:0]};

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_alu[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
  end

  // Halfword select ignores alu[0]; misalignment is trapped upstream if at all.
  assign w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    w_load = r_rdata;
    case (w_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_result = r_alu;
    if (w_opc == OPC_LOAD) begin
      w_result = w_load;
    end else if ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) begin
      w_result = r_pc4;
    end
  end

  assign w_writes_rf = (w_opc != OPC_STORE) && (w_opc != OPC_BRANCH) && (w_rd != 5'd0);

  assign bus.w_valid  = r_valid;
  assign bus.rf_we    = r_valid && w_writes_rf;
  assign bus.rf_rd    = r_valid ? w_rd : 5'd0;
  assign bus.rf_wdata = r_valid ? w_result : 32'h0;
  assign bus.instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed load/jump/stall/flush/reset cases with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_wb_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(64)) bus ();

  wb_stage #(.NOP_INSTR(NOP), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of the W slot and retire count.
  logic        mv_valid = 1'b0;
  logic [31:0] mv_instr = NOP;
  logic [31:0] mv_alu   = 32'h0;
  logic [31:0] mv_rdata = 32'h0;
  logic [31:0] mv_pc4   = 32'h0;
  logic [63:0] mv_cnt   = 64'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_valid = 1'b0; mv_instr = NOP; mv_alu = 0; mv_rdata = 0; mv_pc4 = 0; mv_cnt = 0;
    end else begin
      if (mv_valid && !bus.stall) mv_cnt = mv_cnt + 1;
      if (bus.flush) begin
        mv_valid = 1'b0; mv_instr = NOP;
      end else if (!bus.stall) begin
        mv_valid = bus.m_valid; mv_instr = bus.m_instr; mv_alu = bus.m_alu_result;
        mv_rdata = bus.m_mem_rdata; mv_pc4 = bus.m_pc_plus4;
      end
    end
  end

  function automatic logic [31:0] exp_wdata(input logic v, input logic [31:0] ins,
                                            input logic [31:0] alu, input logic [31:0] rdata,
                                            input logic [31:0] pc4);
    int unsigned opc, f3, off, b, h;
    opc = (ins >> 2) % 32;
    f3  = (ins >> 12) % 8;
    off = alu % 4;
    b   = (rdata >> (off * 8)) % 256;
    h   = (rdata >> (((alu / 2) % 2) * 16)) % 65536;
    if (!v) return 32'h0;
    if (opc == 27 || opc == 25) return pc4;
    if (opc != 0) return alu;
    case (f3)
      0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      4: return 32'(b);
      1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5: return 32'(h);
      default: return rdata;
    endcase
  endfunction

  function automatic logic exp_we(input logic v, input logic [31:0] ins);
    int unsigned opc, rd;
    opc = (ins >> 2) % 32;
    rd  = (ins >> 7) % 32;
    return v && opc != 8 && opc != 24 && rd != 0;
  endfunction

  always @(negedge clk) begin
    chk("w_valid",  {63'h0, bus.w_valid}, {63'h0, mv_valid});
    chk("rf_we",    {63'h0, bus.rf_we},   {63'h0, exp_we(mv_valid, mv_instr)});
    chk("rf_rd",    {59'h0, bus.rf_rd},   mv_valid ? {59'h0, mv_instr[11:7]} : 64'h0);
    chk("rf_wdata", {32'h0, bus.rf_wdata},
        {32'h0, exp_wdata(mv_valid, mv_instr, mv_alu, mv_rdata, mv_pc4)});
    chk("instret",  bus.instret, mv_cnt);
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic st, input logic fl);
    bus.m_valid = v; bus.m_instr = ins; bus.m_alu_result = alu;
    bus.m_mem_rdata = rdata; bus.m_pc_plus4 = pc4; bus.stall = st; bus.flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] i_load(input logic [4:0] rd, input logic [2:0] f3);
    return {12'h0, 5'd1, f3, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd);
    return {7'h0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic rand_cycles(input int n);
    logic [4:0] opcs [8];
    logic [31:0] r;
    opcs = '{5'b00000, 5'b01000, 5'b11000, 5'b00100, 5'b01100, 5'b11011, 5'b11001, 5'b01101};
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      drive(($urandom_range(0, 3) != 0), {r[31:7], opcs[$urandom_range(0, 7)], 2'b11},
            $urandom(), $urandom(), $urandom(),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    bus.m_valid = 0; bus.m_instr = NOP; bus.m_alu_result = 0; bus.m_mem_rdata = 0;
    bus.m_pc_plus4 = 0; bus.stall = 0; bus.flush = 0;
    #1 rst_n = 1'b0;
    #2 chk("reset_instret", bus.instret, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rand_cycles(200);
    drive(1, i_add(5'd3), 32'h1234, 0, 0, 0, 0);
    chk("pre_reset_valid", {63'h0, bus.w_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",   {63'h0, bus.w_valid}, 64'h0);
    chk("async_rst_we",      {63'h0, bus.rf_we}, 64'h0);
    chk("async_rst_instret", bus.instret, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, i_load(5'd5, 3'b000), 32'h1002, 32'h1280_3456, 0, 0, 0);
    chk("lb_we",    {63'h0, bus.rf_we}, 64'h1);
    chk("lb_rd",    {59'h0, bus.rf_rd}, 64'd5);
    chk("lb_wdata", {32'h0, bus.rf_wdata}, 64'hFFFF_FF80);
    drive(1, i_load(5'd6, 3'b101), 32'h2002, 32'hBEEF_1234, 0, 0, 0);
    chk("lhu_wdata", {32'h0, bus.rf_wdata}, 64'h0000_BEEF);
    chk("cnt_1", bus.instret, 64'd1);
    drive(1, i_load(5'd7, 3'b001), 32'h2000, 32'hBEEF_1234, 0, 0, 0);
    chk("lh_wdata", {32'h0, bus.rf_wdata}, 64'h0000_1234);
    drive(1, {7'h0, 5'd2, 5'd1, 3'b010, 5'd7, 7'b0100011}, 32'h40, 0, 0, 0, 0);
    chk("sw_we", {63'h0, bus.rf_we}, 64'h0);
    drive(1, {7'h0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 32'h0, 0, 0, 0, 0);
    chk("beq_we", {63'h0, bus.rf_we}, 64'h0);
    chk("cnt_4", bus.instret, 64'd4);
    drive(1, {12'h5, 5'd1, 3'b000, 5'd0, 7'b0010011}, 32'h5, 0, 0, 0, 0);
    chk("addi_x0_we", {63'h0, bus.rf_we}, 64'h0);
    drive(1, {20'h0, 5'd1, 7'b1101111}, 32'hDEAD, 0, 32'h104, 0, 0);
    chk("jal_rd",    {59'h0, bus.rf_rd}, 64'd1);
    chk("jal_wdata", {32'h0, bus.rf_wdata}, 64'h104);
    chk("cnt_6", bus.instret, 64'd6);
    drive(1, i_add(5'd3), 32'h55, 0, 32'h108, 0, 0);
    chk("add_b2b_wdata", {32'h0, bus.rf_wdata}, 64'h55);
    drive(1, i_add(5'd4), 32'h77, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, i_add(5'd9), 32'h99, 0, 0, 1, 0);
      chk("stall_rd",      {59'h0, bus.rf_rd}, 64'd4);
      chk("stall_wdata",   {32'h0, bus.rf_wdata}, 64'h77);
      chk("stall_instret", bus.instret, 64'd8);
    end
    drive(0, NOP, 0, 0, 0, 0, 0);
    chk("release_instret", bus.instret, 64'd9);
    drive(1, i_add(5'd6), 32'h66, 0, 0, 0, 0);
    drive(1, i_add(5'd9), 32'h99, 0, 0, 1, 1);
    chk("stall_flush_valid",   {63'h0, bus.w_valid}, 64'h0);
    chk("stall_flush_instret", bus.instret, 64'd9);
    drive(0, NOP, 0, 0, 0, 0, 0);
    chk("after_flush_instret", bus.instret, 64'd9);

    rand_cycles(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
